// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two cache-client ports and the main-memory line
// port that mem_arbiter sits between.
//   Client side : c_rd_req/c_wr_req/c_addr/c_wr_line in, c_rd_line/c_gnt out
//   Memory side : mem_addr/mem_rd_req/mem_wr_req/mem_wr_line out,
//                 mem_rd_line/mem_gnt in
//   Status      : grant_cnt, completed transactions per client
// slave  : used by the arbiter itself
// master : used by whatever drives the clients and models main memory
interface mem_arbiter_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10,
    parameter int CNT_W         = 16
);
    localparam int LINE_W = 32 * (1 << LINE_ADDR_LEN);

    logic [1:0]          c_rd_req;
    logic [1:0]          c_wr_req;
    logic [ADDR_LEN-1:0] c_addr    [2];
    logic [LINE_W-1:0]   c_wr_line [2];
    logic [LINE_W-1:0]   c_rd_line [2];
    logic [1:0]          c_gnt;

    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_rd_req;
    logic                mem_wr_req;
    logic [LINE_W-1:0]   mem_wr_line;
    logic [LINE_W-1:0]   mem_rd_line;
    logic                mem_gnt;

    logic [CNT_W-1:0]    grant_cnt [2];

    modport slave (
        input  c_rd_req, c_wr_req, c_addr, c_wr_line, mem_rd_line, mem_gnt,
        output c_rd_line, c_gnt, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line,
               grant_cnt
    );

    modport master (
        output c_rd_req, c_wr_req, c_addr, c_wr_line, mem_rd_line, mem_gnt,
        input  c_rd_line, c_gnt, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line,
               grant_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory line port between the I-cache
// (client 0) and the D-cache (client 1). One transaction at a time, chosen
// round-robin; the owner's request is forwarded, mem_gnt is routed back to the
// owner only, and each client's last read line is held locally.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (client ports, memory port, grant counters)
module mem_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10,
    parameter int CNT_W         = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    localparam int LINE_W = 32 * (1 << LINE_ADDR_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_prio;
    logic [LINE_W-1:0]   r_rd_line   [2];
    logic [CNT_W-1:0]    r_grant_cnt [2];

    logic [1:0]          w_req;
    logic                w_owner_wr;
    logic                w_owner_rd;
    logic [ADDR_LEN-1:0] w_mem_addr;
    logic [LINE_W-1:0]   w_mem_wr_line;
    logic                w_mem_rd_req;
    logic                w_mem_wr_req;
    logic [1:0]          w_gnt;

    assign w_req      = bus.c_rd_req | bus.c_wr_req;
    // A simultaneous read+write from one client is treated as a write only.
    assign w_owner_wr = bus.c_wr_req[r_owner];
    assign w_owner_rd = bus.c_rd_req[r_owner] & ~w_owner_wr;

    // Memory-side request and client grant follow the owner combinationally
    // while BUSY; everything is forced low in IDLE so requests drop between
    // transactions.
    always_comb begin
        w_mem_addr    = '0;
        w_mem_wr_line = '0;
        w_mem_rd_req  = 1'b0;
        w_mem_wr_req  = 1'b0;
        w_gnt         = '0;
        if (r_state == BUSY) begin
            w_mem_addr     = bus.c_addr[r_owner];
            w_mem_wr_line  = bus.c_wr_line[r_owner];
            w_mem_wr_req   = w_owner_wr;
            w_mem_rd_req   = w_owner_rd;
            w_gnt[r_owner] = bus.mem_gnt;
        end
    end

    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wr_line  = w_mem_wr_line;
    assign bus.mem_rd_req   = w_mem_rd_req;
    assign bus.mem_wr_req   = w_mem_wr_req;
    assign bus.c_gnt        = w_gnt;
    assign bus.c_rd_line[0] = r_rd_line[0];
    assign bus.c_rd_line[1] = r_rd_line[1];
    assign bus.grant_cnt[0] = r_grant_cnt[0];
    assign bus.grant_cnt[1] = r_grant_cnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_rd_line[i]   <= '0;
                r_grant_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_state <= BUSY;
                        // Tie goes to r_prio; otherwise the lone requester.
                        r_owner <= (&w_req) ? r_prio : w_req[1];
                    end
                end
                BUSY: begin
                    if (bus.mem_gnt) begin
                        if (w_owner_rd)
                            r_rd_line[r_owner] <= bus.mem_rd_line;
                        r_grant_cnt[r_owner] <= r_grant_cnt[r_owner] + CNT_W'(1);
                        r_prio  <= ~r_owner;
                        r_state <= IDLE;
                    end else if (!w_req[r_owner]) begin
                        // Owner withdrew before completion: no grant, turn kept.
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
